dcmi_frame_gen: RTL and testbench

DCMI_FRAME_GEN -- requirements
Module: dcmi_frame_gen

---
 rtl/dcmi_frame_gen.sv | 223 ++++++++++++++++++++++
 tb/tb_dcmi_frame_gen.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcmi_frame_gen.sv
// DCMI test-frame generator: emits frames of synthetic pixels with either
// external vsync/hsync framing or embedded FF-00-00-code sync sequences.
module dcmi_frame_gen #(
   parameter int unsigned DW = 14,
   parameter int unsigned CW = 14
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic          snapshot,
   input  logic          embd_en,
   input  logic          vsync_pol,
   input  logic          hsync_pol,
   input  logic [1:0]    pat_mode,
   input  logic [DW-1:0] pat_seed,
   input  logic [CW-1:0] line_size,
   input  logic [CW-1:0] pixel_size,
   input  logic [7:0]    hblank,
   input  logic [7:0]    vblank,
   input  logic [7:0]    fsc,
   input  logic [7:0]    fec,
   input  logic [7:0]    lsc,
   input  logic [7:0]    lec,
   output logic          dcmi_vsync,
   output logic          dcmi_hsync,
   output logic [DW-1:0] dcmi_data,
   output logic          data_valid,
   output logic          busy,
   output logic          frame_done,
   output logic          cfg_err
);

   localparam int unsigned NW = (CW > 8) ? CW : 8;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_VBLK = 3'd1;
   localparam logic [2:0] S_FS   = 3'd2;
   localparam logic [2:0] S_HBLK = 3'd3;
   localparam logic [2:0] S_SAV  = 3'd4;
   localparam logic [2:0] S_LINE = 3'd5;
   localparam logic [2:0] S_EAV  = 3'd6;
   localparam logic [2:0] S_FE   = 3'd7;

   logic [2:0]    state, state_n;
   logic [NW-1:0] cnt, cnt_n, last, fe_last;
   logic [CW-1:0] line_idx, line_n;
   logic [DW-1:0] pix_cnt, pix_n, pix_val, data_n;
   logic          stop_pend, stop_pend_n;
   logic          frame_act, frame_act_n, line_act;
   logic          cfg_err_n, latch_cfg;
   logic [7:0]    code, code_byte;

   logic          snapshot_q, embd_q, vpol_q, hpol_q;
   logic [1:0]    pat_q;
   logic [DW-1:0] seed_q;
   logic [CW-1:0] lines_q, pixels_q;
   logic [7:0]    hblank_q, vblank_q, fsc_q, fec_q, lsc_q, lec_q;

   // Config is captured on every VBLK entry, which includes an accepted start.
   assign latch_cfg = (state_n == S_VBLK) && (state != S_VBLK);
   assign fe_last   = embd_q ? NW'(3) : '0;

   // Final count value of the current state.
   always_comb begin
      last = '0;
      case (state)
         S_VBLK: last = (vblank_q == 8'd0) ? '0 : NW'(vblank_q - 8'd1);
         S_HBLK: last = (hblank_q == 8'd0) ? '0 : NW'(hblank_q - 8'd1);
         S_FS, S_SAV, S_EAV, S_FE: last = fe_last;
         S_LINE: last = NW'(pixels_q - CW'(1));
         default: last = '0;
      endcase
   end

   // Next-state, counters and stop bookkeeping.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt + NW'(1);
      line_n    = line_idx;
      pix_n     = pix_cnt;
      cfg_err_n = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if ((line_size == '0) || (pixel_size == '0)) cfg_err_n = 1'b1;
               else                                         state_n   = S_VBLK;
            end
         end
         S_VBLK: if (cnt == last) state_n = S_FS;
         S_FS: begin
            line_n = '0;
            pix_n  = '0;
            if (cnt == last) state_n = S_HBLK;
         end
         S_HBLK: if (cnt == last) state_n = S_SAV;
         S_SAV:  if (cnt == last) state_n = S_LINE;
         S_LINE: if (cnt == last) state_n = S_EAV;
         S_EAV: begin
            if (cnt == last) begin
               line_n  = line_idx + CW'(1);
               state_n = (line_idx == lines_q - CW'(1)) ? S_FE : S_HBLK;
            end
         end
         S_FE: begin
            if (cnt == last)
               state_n = (snapshot_q || stop_pend || stop) ? S_IDLE : S_VBLK;
         end
         default: state_n = S_IDLE;
      endcase
      if ((state_n != state) || (state == S_IDLE)) cnt_n = '0;
      if (state_n == S_LINE) pix_n = pix_cnt + DW'(1);

      stop_pend_n = stop_pend;
      if (state_n == S_IDLE) stop_pend_n = 1'b0;
      else if (stop)         stop_pend_n = 1'b1;

      frame_act_n = frame_act;
      if ((state == S_FS) && (state_n != S_FS)) frame_act_n = 1'b1;
      if ((state == S_FE) && (state_n != S_FE)) frame_act_n = 1'b0;
      if (embd_q)                               frame_act_n = 1'b0;
   end

   // Pixel pattern with embedded-mode escaping of reserved top bytes.
   always_comb begin
      case (pat_q)
         2'b01:   pix_val = seed_q;
         2'b10:   pix_val = DW'(line_idx);
         default: pix_val = pix_cnt;
      endcase
      if (embd_q) begin
         if (pix_val[DW-1 -: 8] == 8'hFF)      pix_val[DW-1 -: 8] = 8'hFE;
         else if (pix_val[DW-1 -: 8] == 8'h00) pix_val[DW-1 -: 8] = 8'h01;
      end
   end

   // Data bus contents for the beat about to be presented.
   always_comb begin
      case (state_n)
         S_FS:    code = fsc_q;
         S_SAV:   code = lsc_q;
         S_EAV:   code = lec_q;
         default: code = fec_q;
      endcase
      if (cnt_n == '0)         code_byte = 8'hFF;
      else if (cnt_n == NW'(3)) code_byte = code;
      else                      code_byte = 8'h00;
      data_n = '0;
      case (state_n)
         S_LINE: data_n = pix_val;
         S_FS, S_SAV, S_EAV, S_FE: if (embd_q) data_n = DW'(code_byte) << (DW - 8);
         default: data_n = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         line_idx   <= '0;
         pix_cnt    <= '0;
         stop_pend  <= 1'b0;
         frame_act  <= 1'b0;
         line_act   <= 1'b0;
         dcmi_data  <= '0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         line_idx   <= line_n;
         pix_cnt    <= pix_n;
         stop_pend  <= stop_pend_n;
         frame_act  <= frame_act_n;
         line_act   <= (state_n == S_LINE) && !embd_q;
         dcmi_data  <= data_n;
         data_valid <= (state_n == S_LINE);
         busy       <= (state_n != S_IDLE);
         frame_done <= (state_n == S_FE) && (cnt_n == fe_last);
         cfg_err    <= cfg_err_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snapshot_q <= 1'b0;
         embd_q     <= 1'b0;
         vpol_q     <= 1'b0;
         hpol_q     <= 1'b0;
         pat_q      <= '0;
         seed_q     <= '0;
         lines_q    <= '0;
         pixels_q   <= '0;
         hblank_q   <= '0;
         vblank_q   <= '0;
         fsc_q      <= '0;
         fec_q      <= '0;
         lsc_q      <= '0;
         lec_q      <= '0;
      end else if (latch_cfg) begin
         snapshot_q <= snapshot;
         embd_q     <= embd_en;
         vpol_q     <= vsync_pol;
         hpol_q     <= hsync_pol;
         pat_q      <= pat_mode;
         seed_q     <= pat_seed;
         lines_q    <= line_size;
         pixels_q   <= pixel_size;
         hblank_q   <= hblank;
         vblank_q   <= vblank;
         fsc_q      <= fsc;
         fec_q      <= fec;
         lsc_q      <= lsc;
         lec_q      <= lec;
      end
   end

   assign dcmi_vsync = vpol_q ^ ~frame_act;
   assign dcmi_hsync = hpol_q ^ ~line_act;

endmodule

// File: tb/tb_dcmi_frame_gen.sv
// Scoreboard bench for dcmi_frame_gen: a frame-level model queues every expected
// busy-cycle beat, and a monitor process pops and compares them.
module tb_dcmi_frame_gen;

   localparam int unsigned DW = 8;
   localparam int unsigned CW = 10;

   logic          clk = 1'b0;
   logic          rst, start, stop, snapshot, embd_en, vsync_pol, hsync_pol;
   logic [1:0]    pat_mode;
   logic [DW-1:0] pat_seed;
   logic [CW-1:0] line_size, pixel_size;
   logic [7:0]    hblank, vblank, fsc, fec, lsc, lec;
   logic          dcmi_vsync, dcmi_hsync, data_valid, busy, frame_done, cfg_err;
   logic [DW-1:0] dcmi_data;

   always #5 clk = ~clk;

   dcmi_frame_gen #(.DW(DW), .CW(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .snapshot(snapshot),
      .embd_en(embd_en), .vsync_pol(vsync_pol), .hsync_pol(hsync_pol),
      .pat_mode(pat_mode), .pat_seed(pat_seed), .line_size(line_size),
      .pixel_size(pixel_size), .hblank(hblank), .vblank(vblank),
      .fsc(fsc), .fec(fec), .lsc(lsc), .lec(lec),
      .dcmi_vsync(dcmi_vsync), .dcmi_hsync(dcmi_hsync), .dcmi_data(dcmi_data),
      .data_valid(data_valid), .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic          valid;
      logic          vs;
      logic          hs;
      logic          fd;
   } beat_t;

   beat_t sb[$];
   int tests = 0, fails = 0, nvalid = 0, nfd = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] pix(input int l, input int k);
      logic [DW-1:0] v;
      case (pat_mode)
         2'b01:   v = pat_seed;
         2'b10:   v = DW'(l);
         default: v = DW'(k);
      endcase
      if (embd_en) begin
         if (v[DW-1 -: 8] == 8'hFF)      v[DW-1 -: 8] = 8'hFE;
         else if (v[DW-1 -: 8] == 8'h00) v[DW-1 -: 8] = 8'h01;
      end
      return v;
   endfunction

   task automatic push(input logic [DW-1:0] d, input logic v, input logic fa,
                       input logic la, input logic fd);
      beat_t b;
      b.data  = d;
      b.valid = v;
      b.vs    = vsync_pol ^ ~fa;
      b.hs    = hsync_pol ^ ~la;
      b.fd    = fd;
      sb.push_back(b);
   endtask

   task automatic push_sync(input logic [7:0] code, input logic is_fe, input logic fa);
      logic [7:0] byt;
      if (embd_en) begin
         for (int i = 0; i < 4; i++) begin
            byt = (i == 0) ? 8'hFF : (i == 3) ? code : 8'h00;
            push(DW'(byt) << (DW - 8), 1'b0, fa, 1'b0, is_fe && (i == 3));
         end
      end else begin
         push('0, 1'b0, fa, 1'b0, is_fe);
      end
   endtask

   // One complete frame as seen from the first VBLK cycle to the last FE cycle.
   task automatic push_frame();
      int vb = (vblank == 8'd0) ? 1 : int'(vblank);
      int hb = (hblank == 8'd0) ? 1 : int'(hblank);
      logic fx = ~embd_en;
      int k = 0;
      for (int i = 0; i < vb; i++) push('0, 1'b0, 1'b0, 1'b0, 1'b0);
      push_sync(fsc, 1'b0, 1'b0);
      for (int l = 0; l < int'(line_size); l++) begin
         for (int i = 0; i < hb; i++) push('0, 1'b0, fx, 1'b0, 1'b0);
         push_sync(lsc, 1'b0, fx);
         for (int p = 0; p < int'(pixel_size); p++) begin
            push(pix(l, k), 1'b1, fx, fx, 1'b0);
            k++;
         end
         push_sync(lec, 1'b0, fx);
      end
      push_sync(fec, 1'b1, fx);
   endtask

   task automatic cfg(input logic snap, input logic emb, input logic vp, input logic hp,
                      input logic [1:0] pm, input logic [DW-1:0] seed,
                      input int ls, input int ps, input int hb, input int vb);
      snapshot = snap; embd_en = emb; vsync_pol = vp; hsync_pol = hp;
      pat_mode = pm; pat_seed = seed;
      line_size = CW'(ls); pixel_size = CW'(ps);
      hblank = 8'(hb); vblank = 8'(vb);
   endtask

   task automatic start_pulse();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      @(negedge clk); #1;
      check({name, " busy_end"}, 32'(busy), 32'd0);
      check({name, " sb_left"}, 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic run_frame(input string name);
      int nv0 = nvalid;
      int nf0 = nfd;
      push_frame();
      start_pulse();
      wait_idle(name);
      check({name, " valid_beats"}, 32'(nvalid - nv0), 32'(int'(line_size) * int'(pixel_size)));
      check({name, " frame_done_cnt"}, 32'(nfd - nf0), 32'd1);
   endtask

   initial begin
      beat_t g, e;
      int n, nv0, nf0, save_ls;
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      cfg(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, '0, 1, 1, 0, 0);
      fsc = 8'h00; fec = 8'h00; lsc = 8'h00; lec = 8'h00;

      fork
         forever begin
            @(negedge clk);
            if (!rst && busy) begin
               g = {dcmi_data, data_valid, dcmi_vsync, dcmi_hsync, frame_done};
               tests++;
               if (sb.size() == 0) begin
                  fails++;
                  $display("FAIL sb_underflow: busy with no expected beat, data=%0h", dcmi_data);
               end else begin
                  e = sb.pop_front();
                  if (g !== e) begin
                     fails++;
                     $display("FAIL beat d/v/vs/hs/fd: got %0h/%b/%b/%b/%b expected %0h/%b/%b/%b/%b",
                              g.data, g.valid, g.vs, g.hs, g.fd, e.data, e.valid, e.vs, e.hs, e.fd);
                  end
               end
               if (data_valid) nvalid++;
               if (frame_done) nfd++;
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      check("rst data", 32'(dcmi_data), 32'd0);
      check("rst valid", 32'(data_valid), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst vsync", 32'(dcmi_vsync), 32'd1);
      check("rst hsync", 32'(dcmi_hsync), 32'd1);
      check("rst frame_done", 32'(frame_done), 32'd0);
      check("rst cfg_err", 32'(cfg_err), 32'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // External snapshot 4x6, counter pattern
      cfg(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, '0, 4, 6, 2, 3);
      run_frame("ext_4x6");

      // Embedded sync codes, constant 0xFF seed escaped to 0xFE
      fsc = 8'hAB; lsc = 8'h80; lec = 8'h9D; fec = 8'hB6;
      cfg(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 8'hFF, 2, 3, 2, 2);
      run_frame("embd_seed_ff");

      // Zero size rejected
      cfg(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, '0, 2, 0, 1, 1);
      start_pulse();
      check("cfg_err pulse", 32'(cfg_err), 32'd1);
      check("cfg_err busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      check("cfg_err one_cycle", 32'(cfg_err), 32'd0);
      check("cfg_err still idle", 32'(busy), 32'd0);

      // Start while busy ignored, including its config
      cfg(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, '0, 3, 4, 1, 2);
      push_frame();
      start_pulse();
      repeat (6) @(posedge clk);
      #1;
      save_ls = int'(line_size);
      line_size = CW'(1);
      start_pulse();
      line_size = CW'(save_ls);
      wait_idle("start_while_busy");

      // Continuous with stop during frame 2
      cfg(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, '0, 2, 4, 1, 2);
      nf0 = nfd;
      push_frame();
      push_frame();
      start_pulse();
      n = 0;
      while (nfd - nf0 < 1 && n < 500) begin @(posedge clk); #1; n++; end
      n = 0;
      while (!data_valid && n < 500) begin @(posedge clk); #1; n++; end
      check("stop reached frame2 line", 32'(data_valid), 32'd1);
      @(posedge clk); #1 stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      wait_idle("continuous_stop");
      check("continuous frame_done_cnt", 32'(nfd - nf0), 32'd2);

      // Reset in the middle of a line, then a clean frame
      cfg(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, '0, 3, 5, 1, 1);
      push_frame();
      start_pulse();
      n = 0;
      while (!data_valid && n < 500) begin @(posedge clk); #1; n++; end
      repeat (2) @(posedge clk);
      #1;
      check("pre_rst in line", 32'(data_valid), 32'd1);
      check("pre_rst pixel", 32'(dcmi_data), 32'd2);
      #2 rst = 1'b1;
      #1;
      check("mid_rst data", 32'(dcmi_data), 32'd0);
      check("mid_rst valid", 32'(data_valid), 32'd0);
      check("mid_rst busy", 32'(busy), 32'd0);
      check("mid_rst vsync", 32'(dcmi_vsync), 32'd1);
      sb.delete();
      @(posedge clk); #1 rst = 1'b0;
      run_frame("after_rst");

      // Zero blanking, line-index pattern, inverted vsync polarity
      cfg(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, '0, 3, 4, 0, 0);
      run_frame("zero_blank_lineidx");

      // Randomized frames
      for (int t = 0; t < 10; t++) begin
         fsc = 8'($urandom); lsc = 8'($urandom); lec = 8'($urandom); fec = 8'($urandom);
         cfg(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), DW'($urandom),
             int'($urandom_range(1, 4)), int'($urandom_range(1, 7)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         run_frame($sformatf("rand%0d", t));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
